// File: rtl/regfile_64bit_if.sv
// Bus bundle for the RV64I integer register file: one write port, two read ports
// and the write-back activity flag consumed by the hazard unit.
interface regfile_64bit_if #(
   parameter int XLEN = 64,
   parameter int AW   = 5
);
   logic            we;
   logic [AW-1:0]   wa;
   logic [XLEN-1:0] wd;
   logic [AW-1:0]   ra1;
   logic [AW-1:0]   ra2;
   logic [XLEN-1:0] rd1;
   logic [XLEN-1:0] rd2;
   logic            wr_busy;

   modport master (
      output we, wa, wd, ra1, ra2,
      input  rd1, rd2, wr_busy
   );

   modport slave (
      input  we, wa, wd, ra1, ra2,
      output rd1, rd2, wr_busy
   );
endinterface

// File: rtl/regfile_64bit.sv
// 32 x 64-bit RV64I register file: two combinational read ports, one synchronous
// write port, hard-wired x0 and optional same-cycle write-to-read bypass.
module regfile_64bit #(
   parameter int XLEN   = 64,
   parameter int NREGS  = 32,
   parameter int AW     = 5,
   parameter bit BYPASS = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   regfile_64bit_if.slave  bus
);

   logic [XLEN-1:0] regs [NREGS];
   logic            wr_busy_q;
   logic            write_nz;

   // A write commits only to a nonzero address; x0 is never stored.
   assign write_nz = bus.we && (bus.wa != '0);

   // NOTE: every storage flop is cleared by the async reset, so this array must
   // stay flop-based; a reset loop like this prevents RAM inference on purpose.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
         wr_busy_q <= 1'b0;
      end else begin
         wr_busy_q <= write_nz;
         if (write_nz) begin
            regs[bus.wa] <= bus.wd;
         end
      end
   end

   // NOTE: each combinational output gets a default first so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      bus.rd1 = '0;
      if (rst_n && (bus.ra1 != '0)) begin
         bus.rd1 = regs[bus.ra1];
         if (BYPASS && write_nz && (bus.wa == bus.ra1)) begin
            bus.rd1 = bus.wd;
         end
      end
   end

   always_comb begin
      bus.rd2 = '0;
      if (rst_n && (bus.ra2 != '0)) begin
         bus.rd2 = regs[bus.ra2];
         if (BYPASS && write_nz && (bus.wa == bus.ra2)) begin
            bus.rd2 = bus.wd;
         end
      end
   end

   assign bus.wr_busy = wr_busy_q;

endmodule

// File: doc/regfile_64bit.md
Name: regfile_64bit

Overview:
- 32-entry x 64-bit integer register file for the RV64I datapath.
- Sits directly downstream of the 6:1 64-bit write-back mux: mux output X drives wd; mux select logic and register file write enable come from the same control decode.
- Two combinational read ports (rs1, rs2) feed the ALU operand muxes; one synchronous write port.
- Optional write-to-read bypass covers same-cycle write-back/decode overlap.

Parameters:
XLEN, 64, data width of each register and of the wd/rd1/rd2 ports
NREGS, 32, number of architectural registers
AW, 5, register address width; must satisfy 2**AW == NREGS
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return pre-edge contents

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset; clears all registers
we  input  1  write enable, sampled at rising clk edge
wa  input  AW  write address (rd field)
wd  input  XLEN  write data (from write-back mux output X)
ra1  input  AW  read address port 1 (rs1 field)
ra2  input  AW  read address port 2 (rs2 field)
rd1  output  XLEN  read data port 1, combinational
rd2  output  XLEN  read data port 2, combinational
wr_busy  output  1  registered; high for one cycle after a committed write to a nonzero register (write-back activity flag for the hazard unit)

Behaviour:
- One clock (clk), asynchronous active-low reset (rst_n). Reset asserts immediately, independent of clk; deassertion takes effect at the next rising edge.
- Reset: all NREGS registers = 0, wr_busy = 0. While rst_n = 0: rd1 = rd2 = 0, writes ignored, bypass suppressed.
- Write: at rising clk, if rst_n = 1 and we = 1 and wa != 0, then reg[wa] <= wd. Visible on a read port no later than the cycle after the edge.
- x0: writes to address 0 are discarded; reads of address 0 always return 0, including when we = 1, wa = 0 and BYPASS = 1.
- Read: rd1 = reg[ra1], rd2 = reg[ra2]; purely combinational, zero-cycle latency. Both ports may address the same register.
- Bypass (BYPASS = 1): if we = 1, wa != 0 and wa == ra1, then rd1 = wd in the same cycle. Same rule applies independently to rd2. Bypass is combinational from wd; wd changes mid-cycle propagate.
- BYPASS = 0: reads return stored contents until the write edge, then the new value.
- wr_busy: at each rising clk, wr_busy <= we & (wa != 0). Cleared asynchronously by reset.
- Back-to-back writes to the same address: last edge wins; no stall.
- Reset asserted mid-cycle while we = 1: the write is lost, and the register stays 0 after reset release.
- X/Z on wa while we = 0: no state change.
- Storage is flop-based, with no RAM inference requirement. Synthesis must not create latches.

Test Plan:
- Reset: rst_n = 0 for 100 ns, then read every address via ra1/ra2 -> rd1 = rd2 = 0, wr_busy = 0.
- Sequential write/read (BYPASS = 1): write wa = 1..6 with wd = 11, 22, 33, 44, 55, 66 on consecutive edges, then sweep ra1 = 1..6, ra2 = 6..1 -> rd1 = 11..66, rd2 = 66..11; wr_busy high each cycle after each write.
- x0 protection: we = 1, wa = 0, wd = 64'hFFFF_FFFF_FFFF_FFFF, ra1 = 0 -> rd1 = 0 in the write cycle and after the edge; wr_busy stays 0.
- Bypass: reg[5] = 55; drive we = 1, wa = 5, wd = 99, ra1 = ra2 = 5 -> rd1 = rd2 = 99 before the edge (BYPASS = 1). Same stimulus with BYPASS = 0 -> 55 before the edge, 99 after.
- Async reset mid-operation: registers 1..6 hold 11..66; drop rst_n between edges with we = 1, wa = 3, wd = 77 -> rd outputs go to 0 immediately; after release, reg[3] = 0 and all other registers = 0.
- Boundary address: write wa = 31, wd = 64'h8000_0000_0000_0001, then ra2 = 31 -> rd2 = 64'h8000_0000_0000_0001, and reg[30] is unchanged (0).
